// File: rtl/count_sequencer_ctrl_if.sv
// Packed I/O bundle for count_sequencer_ctrl: clock, reset and controls in, status out.
// Bit map: io_in = {clk, rst, start, pause, limit[3:0]}, io_out = {state[1:0], done, busy, count[3:0]}.
// The driver side owns io_in, the sequencer side owns io_out.
interface count_sequencer_ctrl_if;
   logic [7:0] io_in;
   logic [7:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/count_sequencer_ctrl.sv
// Start-edge launched up-counter from 0 to a sampled limit, with pause, done pulse and optional auto-restart.
// Latency: every output is a register; input changes show on io_out after the next rising clock edge.
// No backpressure: start, pause and limit are sampled every cycle and never stalled.
module count_sequencer_ctrl #(
   parameter bit AUTO_RESTART = 1'b0
) (
   count_sequencer_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   logic       clk;
   logic       rst;
   logic       start_i;
   logic       pause_i;
   logic [3:0] limit_i;

   assign clk     = bus.io_in[7];
   assign rst     = bus.io_in[6];
   assign start_i = bus.io_in[5];
   assign pause_i = bus.io_in[4];
   assign limit_i = bus.io_in[3:0];

   state_t     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic [3:0] limit_q, limit_d;
   logic       start_q;
   logic       done_q, done_d;
   logic       start_edge;
   logic       busy;

   // A start held high relaunches only once: the edge needs start low in the previous cycle.
   assign start_edge = start_i & ~start_q;

   // Next-state logic; start edge overrides everything, then pause, then the terminal-count check.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      done_d  = 1'b0;
      if (start_edge) begin
         state_d = ST_RUN;
         count_d = 4'd0;
         limit_d = limit_i;
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_d = 4'd0;
            end
            ST_RUN: begin
               if (pause_i) begin
                  state_d = ST_PAUSE;
               end else if (count_q != limit_q) begin
                  // count only advances while below the limit, so it can never wrap
                  count_d = count_q + 4'd1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
            ST_PAUSE: begin
               // the resume edge only changes state; counting restarts on the edge after
               if (!pause_i) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (AUTO_RESTART) begin
                  state_d = ST_RUN;
                  count_d = 4'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = 4'd0;
            end
         endcase
      end
   end

   // State registers; reset clears everything immediately so io_out reads 0x00 without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= 4'd0;
         limit_q <= 4'd0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         start_q <= start_i;
         done_q  <= done_d;
      end
   end

   // busy decodes registered state only, so io_out has no path from io_in
   assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);

   assign bus.io_out = {state_q, done_q, busy, count_q};

endmodule

// File: tb/tb_count_sequencer_ctrl.sv
// Directed bench for count_sequencer_ctrl: one instance without and one with auto-restart.
// Inputs change 1 time unit after a rising edge and io_out is sampled at that same point.
// Expected io_out words are hand-computed constants built from {state, done, busy, count}.
module tb_count_sequencer_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       pause;
   logic [3:0] limit;

   int ntot  = 0;
   int npass = 0;

   count_sequencer_ctrl_if bus_a ();
   count_sequencer_ctrl_if bus_b ();

   assign bus_a.io_in = {clk, rst, start, pause, limit};
   assign bus_b.io_in = {clk, rst, start, pause, limit};

   count_sequencer_ctrl #(.AUTO_RESTART(1'b0)) dut_a (.bus(bus_a.slave));
   count_sequencer_ctrl #(.AUTO_RESTART(1'b1)) dut_b (.bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output word: state code, done, busy (RUN or PAUSE), count.
   function automatic logic [7:0] ow(input logic [1:0] st, input logic dn, input logic [3:0] cnt);
      logic bz;
      bz = (st == 2'b01) || (st == 2'b10);
      return {st, dn, bz, cnt};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      ntot++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      limit = 4'd0;
      #2;
      chk("reset_async_a", bus_a.io_out, 8'h00);
      chk("reset_async_b", bus_b.io_out, 8'h00);
      tick();
      chk("reset_clocked", bus_a.io_out, 8'h00);
      rst = 1'b0;
      tick();
      chk("idle_after_reset", bus_a.io_out, ow(2'b00, 1'b0, 4'd0));

      // basic count to 3
      limit = 4'd3;
      start = 1'b1;
      tick();
      chk("basic_run0", bus_a.io_out, 8'h50);
      start = 1'b0;
      limit = 4'd12;
      tick();
      chk("basic_run1", bus_a.io_out, ow(2'b01, 1'b0, 4'd1));
      tick();
      chk("basic_run2", bus_a.io_out, ow(2'b01, 1'b0, 4'd2));
      tick();
      chk("basic_run3", bus_a.io_out, 8'h53);
      tick();
      chk("basic_done_pulse", bus_a.io_out, 8'hE3);
      tick();
      chk("basic_done_hold", bus_a.io_out, 8'hC3);
      tick();
      chk("basic_done_stay", bus_a.io_out, 8'hC3);

      // pause at count 2 for three cycles, limit 5
      limit = 4'd5;
      start = 1'b1;
      tick();
      chk("pause_run0", bus_a.io_out, 8'h50);
      start = 1'b0;
      tick();
      chk("pause_run1", bus_a.io_out, 8'h51);
      tick();
      chk("pause_run2", bus_a.io_out, 8'h52);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_hold", bus_a.io_out, 8'h92);
      end
      pause = 1'b0;
      tick();
      chk("pause_resume_edge", bus_a.io_out, 8'h52);
      tick();
      chk("pause_resume_3", bus_a.io_out, 8'h53);
      tick();
      chk("pause_resume_4", bus_a.io_out, 8'h54);
      tick();
      chk("pause_resume_5", bus_a.io_out, 8'h55);
      tick();
      chk("pause_done_pulse", bus_a.io_out, 8'hE5);
      tick();
      chk("pause_done_hold", bus_a.io_out, 8'hC5);

      // restart mid-count: limit 9, relaunch at count 4 with limit 2
      limit = 4'd9;
      start = 1'b1;
      tick();
      chk("restart_run0", bus_a.io_out, 8'h50);
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("restart_first_run", bus_a.io_out, ow(2'b01, 1'b0, 4'(i)));
      end
      start = 1'b1;
      limit = 4'd2;
      tick();
      chk("restart_relaunch0", bus_a.io_out, 8'h50);
      start = 1'b0;
      limit = 4'd9;
      tick();
      chk("restart_run1", bus_a.io_out, 8'h51);
      tick();
      chk("restart_run2", bus_a.io_out, 8'h52);
      tick();
      chk("restart_done_pulse", bus_a.io_out, 8'hE2);
      tick();
      chk("restart_done_hold", bus_a.io_out, 8'hC2);

      // limit 0 with start held high for 10 cycles
      limit = 4'd0;
      start = 1'b1;
      tick();
      chk("lim0_run0", bus_a.io_out, 8'h50);
      tick();
      chk("lim0_done_pulse", bus_a.io_out, 8'hE0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("start_held_no_relaunch", bus_a.io_out, 8'hC0);
      end
      start = 1'b0;
      tick();
      chk("start_released", bus_a.io_out, 8'hC0);

      // async reset between clock edges while running
      limit = 4'd7;
      start = 1'b1;
      tick();
      chk("rstrun_run0", bus_a.io_out, 8'h50);
      start = 1'b0;
      tick();
      chk("rstrun_run1", bus_a.io_out, 8'h51);
      tick();
      chk("rstrun_run2", bus_a.io_out, 8'h52);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_mid_run_async", bus_a.io_out, 8'h00);
      tick();
      chk("rst_mid_run_held", bus_a.io_out, 8'h00);
      // start high on the first edge after release is a launch
      rst   = 1'b0;
      start = 1'b1;
      limit = 4'd1;
      tick();
      chk("rst_release_start", bus_a.io_out, 8'h50);
      start = 1'b0;

      // reset during pause aborts without a done pulse
      tick();
      chk("rstpause_run1", bus_a.io_out, 8'h51);
      limit = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      pause = 1'b1;
      tick();
      chk("rstpause_paused", bus_a.io_out, 8'h90);
      rst = 1'b1;
      #1;
      chk("rst_mid_pause_async", bus_a.io_out, 8'h00);
      pause = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_pause_idle", bus_a.io_out, 8'h00);

      // auto-restart instance, limit 1: 0,1,DONE repeating
      limit = 4'd1;
      start = 1'b1;
      tick();
      chk("auto_run0_a", bus_b.io_out, 8'h50);
      start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("auto_run1", bus_b.io_out, 8'h51);
         tick();
         chk("auto_done_pulse", bus_b.io_out, 8'hE1);
         tick();
         chk("auto_restart0", bus_b.io_out, 8'h50);
      end
      chk("noauto_done_hold", bus_a.io_out, 8'hC1);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
